// File: rtl/tnn_mem_pkg.sv
// ---------------------------------------------------------------------------
// tnn_mem_pkg
// Shared types and constants for the image-memory read path of the TNN
// column: requester ID type, the {valid, id} tag carried alongside each
// outstanding read, and the default memory geometry.
//
// The ID type is sized from DEFAULT_NUM_REQ. Any arbiter instance must use
// a NUM_REQ whose $clog2 fits req_id_t; raise DEFAULT_NUM_REQ for wider
// configurations.
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif
`ifndef MEM_WORD_BITS
`define MEM_WORD_BITS 32
`endif

package tnn_mem_pkg;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_MEM_LATENCY = 2;
    localparam int REQ_ID_BITS         = $clog2(DEFAULT_NUM_REQ);

    typedef logic [REQ_ID_BITS-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/pixel_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Starting at ptr_i and searching
// upward with wrap-around, selects the first set bit of eligible_i.
//
// Ports:
//   eligible_i   [NUM_REQ]  candidate vector
//   ptr_i        req_id_t   index with highest priority this cycle
//   any_o        1          at least one candidate is eligible
//   grant_oh_o   [NUM_REQ]  one-hot grant (all zero when any_o = 0)
//   grant_idx_o  req_id_t   index of the granted candidate
// ---------------------------------------------------------------------------
module rr_pick
    import tnn_mem_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  req_id_t            ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output req_id_t            grant_idx_o
);

    // Wrap is done by subtraction rather than by bit truncation so that a
    // non-power-of-two NUM_REQ never visits an index past NUM_REQ-1.
    always_comb begin
        int      cand;
        req_id_t candIdx;
        any_o       = 1'b0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        cand        = 0;
        candIdx     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = cand[REQ_ID_BITS-1:0];
            if (!any_o && eligible_i[candIdx]) begin
                any_o               = 1'b1;
                grant_oh_o[candIdx] = 1'b1;
                grant_idx_o         = candIdx;
            end
        end
    end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_mem_arbiter
// Shares one fixed-latency image-memory read port between NUM_REQ
// receptive-field fetch units. Requests are granted round-robin, one read
// per cycle, with at most one outstanding read per unit. A MEM_LATENCY-deep
// tag pipeline follows each read so the returning word is flagged to the
// unit that asked for it.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   req          [NUM_REQ]            per-unit read request
//   req_addr     [NUM_REQ][ADDR_BITS] per-unit address, sampled at grant
//   mem_ready    1                    memory can accept a read
//   mem_rdata    [WORD_BITS]          memory data, MEM_LATENCY after issue
//   mem_rd       1                    registered read strobe
//   mem_addr     [ADDR_BITS]          registered read address
//   rd_data      [WORD_BITS]          mem_rdata broadcast to all units
//   data_valid   [NUM_REQ]            one-hot owner of rd_data
//   busy         1                    some read is in flight
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif
`ifndef MEM_WORD_BITS
`define MEM_WORD_BITS 32
`endif

module pixel_mem_arbiter
    import tnn_mem_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int ADDR_BITS   = `MEM_ADDR_BITS,
    parameter int WORD_BITS   = `MEM_WORD_BITS,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_addr,
    input  logic                              mem_ready,
    input  logic [WORD_BITS-1:0]              mem_rdata,
    output logic                              mem_rd,
    output logic [ADDR_BITS-1:0]              mem_addr,
    output logic [WORD_BITS-1:0]              rd_data,
    output logic [NUM_REQ-1:0]                data_valid,
    output logic                              busy
);

    logic [NUM_REQ-1:0]   pending_q, pending_d;
    req_id_t              ptr_q, ptr_d;
    logic                 memRd_q;
    logic [ADDR_BITS-1:0] memAddr_q;
    req_id_t              grantId_q;
    rd_tag_t              tagPipe_q [MEM_LATENCY];

    logic [NUM_REQ-1:0]   eligible;
    logic                 pickAny;
    logic [NUM_REQ-1:0]   pickOh;
    req_id_t              pickIdx;
    logic                 issue;
    rd_tag_t              tail;
    logic [NUM_REQ-1:0]   retMask;

    assign eligible = req & ~pending_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .any_o       (pickAny),
        .grant_oh_o  (pickOh),
        .grant_idx_o (pickIdx)
    );

    assign issue = mem_ready & pickAny;
    assign tail  = tagPipe_q[MEM_LATENCY-1];

    always_comb begin
        retMask = '0;
        if (tail.valid) begin
            retMask[tail.id] = 1'b1;
        end
    end

    // Pending is set on the same edge that registers the issue, so the
    // granted unit is already ineligible during its issue cycle. A return
    // and a grant never target the same unit, since a returning unit is
    // still pending.
    always_comb begin
        pending_d = (pending_q & ~retMask) | (issue ? pickOh : '0);
        ptr_d     = ptr_q;
        if (issue) begin
            ptr_d = (pickIdx == req_id_t'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
        end
    end

    // The tag pipeline is loaded from the registered issue outputs and
    // shifts unconditionally, so its tail lines up with mem_rdata exactly
    // MEM_LATENCY cycles after mem_rd. Reset empties it, which discards any
    // in-flight return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            ptr_q     <= '0;
            memRd_q   <= 1'b0;
            memAddr_q <= '0;
            grantId_q <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                tagPipe_q[s] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            memRd_q   <= issue;
            if (issue) begin
                memAddr_q <= req_addr[pickIdx];
                grantId_q <= pickIdx;
            end
            tagPipe_q[0] <= '{valid: memRd_q, id: grantId_q};
            for (int s = 1; s < MEM_LATENCY; s++) begin
                tagPipe_q[s] <= tagPipe_q[s-1];
            end
        end
    end

    assign mem_rd     = memRd_q;
    assign mem_addr   = memAddr_q;
    assign rd_data    = mem_rdata;
    assign data_valid = retMask;
    assign busy       = |pending_q;

endmodule
